// File: rtl/switch_src_arbiter.sv
// switch_src_arbiter
// Round-robin arbiter that shares the single switch source port among
// NUM_PORTS packet requesters. The winning payload is captured into an
// output register and held stable until the switch accepts it. The winner
// gets a one-cycle ack, and accepted packets are counted with saturation.

module switch_src_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W    = 48,
    parameter int DATA_W    = 32,
    parameter int CNT_W     = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_PORTS-1:0]           req,
    input  logic [NUM_PORTS*ADDR_W-1:0]    req_addr,
    input  logic [NUM_PORTS*DATA_W-1:0]    req_data,
    output logic [NUM_PORTS-1:0]           ack,
    output logic [ADDR_W-1:0]              src_addr,
    output logic [DATA_W-1:0]              src_data,
    output logic                           src_valid,
    input  logic                           src_ready,
    output logic [$clog2(NUM_PORTS)-1:0]   grant_port,
    output logic [CNT_W-1:0]               pkt_count
);

    localparam int PTR_W = $clog2(NUM_PORTS);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                 state;
    logic [PTR_W-1:0]       rr_ptr;
    logic [PTR_W-1:0]       winner;
    logic [PTR_W-1:0]       next_ptr;
    logic [NUM_PORTS-1:0]   eligible;
    logic [NUM_PORTS-1:0]   winner_onehot;
    logic                   found;
    logic                   capture;
    logic                   deliver;
    logic [ADDR_W-1:0]      sel_addr;
    logic [DATA_W-1:0]      sel_data;
    int                     scan_idx;

    // A port whose ack is high this cycle still shows its old payload, so it
    // is masked out to avoid capturing the same packet twice.
    assign eligible = req & ~ack;

    // The output register is free when empty, or when its current packet is
    // being accepted at this edge.
    assign deliver = src_valid && src_ready;
    assign capture = (|eligible) && ((state == IDLE) || deliver);

    // Pick the first eligible port scanning upward from rr_ptr with wrap.
    always_comb begin
        winner   = '0;
        found    = 1'b0;
        scan_idx = 0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            scan_idx = (int'(rr_ptr) + k) % NUM_PORTS;
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (!found && (i == scan_idx) && eligible[i]) begin
                    found  = 1'b1;
                    winner = PTR_W'(i);
                end
            end
        end
    end

    // Route the winner's payload and build its one-hot ack pattern.
    always_comb begin
        sel_addr      = '0;
        sel_data      = '0;
        winner_onehot = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (PTR_W'(i) == winner) begin
                sel_addr         = req_addr[i*ADDR_W +: ADDR_W];
                sel_data         = req_data[i*DATA_W +: DATA_W];
                winner_onehot[i] = 1'b1;
            end
        end
    end

    // Pointer moves just past the winner so it gets lowest priority next time.
    always_comb begin
        if (winner == PTR_W'(NUM_PORTS - 1)) begin
            next_ptr = '0;
        end else begin
            next_ptr = winner + 1'b1;
        end
    end

    // Control FSM with registered outputs and the saturating delivery counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            ack        <= '0;
            src_addr   <= '0;
            src_data   <= '0;
            src_valid  <= 1'b0;
            grant_port <= '0;
            pkt_count  <= '0;
        end else begin
            ack <= '0;

            if (deliver && (pkt_count != {CNT_W{1'b1}})) begin
                pkt_count <= pkt_count + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (capture) begin
                        src_addr   <= sel_addr;
                        src_data   <= sel_data;
                        grant_port <= winner;
                        ack        <= winner_onehot;
                        rr_ptr     <= next_ptr;
                        src_valid  <= 1'b1;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (capture) begin
                        src_addr   <= sel_addr;
                        src_data   <= sel_data;
                        grant_port <= winner;
                        ack        <= winner_onehot;
                        rr_ptr     <= next_ptr;
                        src_valid  <= 1'b1;
                        state      <= HOLD;
                    end else if (src_ready) begin
                        src_valid  <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    src_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_switch_src_arbiter.sv
// tb_switch_src_arbiter
// Directed bench for the source-port arbiter. Expected grants are queued as
// stimulus is set up and checked whenever the DUT raises an ack.

module tb_switch_src_arbiter;

    localparam int N  = 4;
    localparam int AW = 48;
    localparam int DW = 32;
    localparam int CW = 4;
    localparam int PW = 2;

    logic              clk;
    logic              reset;
    logic [N-1:0]      req;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      ack;
    logic [AW-1:0]     src_addr;
    logic [DW-1:0]     src_data;
    logic              src_valid;
    logic              src_ready;
    logic [PW-1:0]     grant_port;
    logic [CW-1:0]     pkt_count;

    typedef struct packed {
        logic [PW-1:0] port;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } pkt_t;

    pkt_t sb_q[$];
    int   remaining[N];
    int   seq[N];
    int   total = 0;
    int   bad = 0;
    int   cycle_no = 0;
    int   last_ack_cycle = -1;
    bit   track_spacing = 0;
    bit   auto_drive = 1;
    logic [AW-1:0] hold_addr;
    logic [DW-1:0] hold_data;

    switch_src_arbiter #(
        .NUM_PORTS (N),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .CNT_W     (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .ack        (ack),
        .src_addr   (src_addr),
        .src_data   (src_data),
        .src_valid  (src_valid),
        .src_ready  (src_ready),
        .grant_port (grant_port),
        .pkt_count  (pkt_count)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [AW-1:0] pay_addr(input int p, input int s);
        return {8'hA0, 8'(p), 32'(s) ^ 32'h1357_0000};
    endfunction

    function automatic logic [DW-1:0] pay_data(input int p, input int s);
        return {8'(p), 8'(s), 16'hBEEF};
    endfunction

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic expect_pkt(input int p, input int s);
        pkt_t e;
        e.port = PW'(p);
        e.addr = pay_addr(p, s);
        e.data = pay_data(p, s);
        sb_q.push_back(e);
    endtask

    // Present the current payload of every port that still has packets.
    task automatic apply_stimulus();
        for (int p = 0; p < N; p++) begin
            if (remaining[p] > 0) begin
                req[p] = 1'b1;
                req_addr[p*AW +: AW] = pay_addr(p, seq[p]);
                req_data[p*DW +: DW] = pay_data(p, seq[p]);
            end else begin
                req[p] = 1'b0;
            end
        end
    endtask

    // Advance one clock, check any ack against the scoreboard, then redrive.
    task automatic step();
        pkt_t e;
        @(posedge clk);
        #1;
        cycle_no++;
        if (ack != '0) begin
            check_output("ack_onehot", 64'($countones(ack)), 64'd1);
            if (sb_q.size() == 0) begin
                check_output("ack_unexpected", 64'(ack), 64'd0);
            end else begin
                e = sb_q.pop_front();
                check_output("ack_port", 64'(ack), 64'(N'(1) << e.port));
                check_output("grant_port", 64'(grant_port), 64'(e.port));
                check_output("src_addr", 64'(src_addr), 64'(e.addr));
                check_output("src_data", 64'(src_data), 64'(e.data));
                check_output("src_valid_on_ack", 64'(src_valid), 64'd1);
            end
            if (track_spacing && last_ack_cycle >= 0) begin
                check_output("ack_spacing", 64'(cycle_no - last_ack_cycle), 64'd2);
            end
            last_ack_cycle = cycle_no;
            for (int p = 0; p < N; p++) begin
                if (ack[p] && remaining[p] > 0) begin
                    remaining[p]--;
                    seq[p]++;
                end
            end
        end
        if (auto_drive) apply_stimulus();
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        for (int p = 0; p < N; p++) begin
            remaining[p] = 0;
            seq[p] = 0;
        end
        sb_q.delete();
        last_ack_cycle = -1;
        apply_stimulus();
        repeat (cycles) step();
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        req       = '0;
        req_addr  = '0;
        req_data  = '0;
        src_ready = 1'b1;

        // Reset state, then idle with no requests.
        $display("[TB] reset and idle");
        do_reset(2);
        check_output("rst_src_valid", 64'(src_valid), 64'd0);
        check_output("rst_ack", 64'(ack), 64'd0);
        check_output("rst_pkt_count", 64'(pkt_count), 64'd0);
        check_output("rst_grant_port", 64'(grant_port), 64'd0);
        check_output("rst_src_addr", 64'(src_addr), 64'd0);
        check_output("rst_src_data", 64'(src_data), 64'd0);
        for (int c = 0; c < 10; c++) begin
            step();
            check_output("idle_src_valid", 64'(src_valid), 64'd0);
            check_output("idle_ack", 64'(ack), 64'd0);
            check_output("idle_pkt_count", 64'(pkt_count), 64'd0);
        end

        // Single packet on port 2 with a fixed payload.
        $display("[TB] single packet port 2");
        auto_drive = 0;
        req_addr[2*AW +: AW] = 48'h0000_1111_2222;
        req_data[2*DW +: DW] = 32'hDEAD_BEEF;
        req = 4'b0100;
        sb_q.push_back('{port: 2'd2, addr: 48'h0000_1111_2222, data: 32'hDEAD_BEEF});
        step();
        check_output("p2_ack", 64'(ack), 64'b0100);
        check_output("p2_src_valid", 64'(src_valid), 64'd1);
        req = '0;
        step();
        check_output("p2_idle_valid", 64'(src_valid), 64'd0);
        check_output("p2_pkt_count", 64'(pkt_count), 64'd1);
        check_output("p2_ack_clear", 64'(ack), 64'd0);
        auto_drive = 1;

        // All four ports requesting continuously, two packets each.
        $display("[TB] round robin all ports");
        do_reset(1);
        for (int p = 0; p < N; p++) remaining[p] = 2;
        for (int s = 0; s < 2; s++)
            for (int p = 0; p < N; p++) expect_pkt(p, s);
        apply_stimulus();
        for (int c = 0; c < 8; c++) begin
            step();
            check_output("rr_ack_each_cycle", 64'(ack != '0), 64'd1);
        end
        step();
        check_output("rr_pkt_count", 64'(pkt_count), 64'd8);
        check_output("rr_idle_valid", 64'(src_valid), 64'd0);
        check_output("rr_sb_empty", 64'(sb_q.size()), 64'd0);

        // Backpressure: port 1 held for five cycles, then accepted.
        $display("[TB] backpressure on port 1");
        src_ready = 1'b0;
        remaining[1] = 1;
        hold_addr = pay_addr(1, seq[1]);
        hold_data = pay_data(1, seq[1]);
        expect_pkt(1, seq[1]);
        apply_stimulus();
        step();
        check_output("bp_first_ack", 64'(ack), 64'b0010);
        check_output("bp_addr_0", 64'(src_addr), 64'(hold_addr));
        for (int c = 1; c < 6; c++) begin
            step();
            if (c == 5) src_ready = 1'b1;
            check_output("bp_addr_stable", 64'(src_addr), 64'(hold_addr));
            check_output("bp_data_stable", 64'(src_data), 64'(hold_data));
            check_output("bp_valid_held", 64'(src_valid), 64'd1);
            check_output("bp_no_ack", 64'(ack), 64'd0);
            check_output("bp_count_held", 64'(pkt_count), 64'd8);
        end
        step();
        check_output("bp_count_after", 64'(pkt_count), 64'd9);
        check_output("bp_valid_after", 64'(src_valid), 64'd0);

        // Reset in the middle of a held packet.
        $display("[TB] reset during hold");
        do_reset(1);
        remaining[2] = 4;
        for (int s = 0; s < 4; s++) expect_pkt(2, s);
        apply_stimulus();
        repeat (7) step();
        check_output("mid_count_pre", 64'(pkt_count), 64'd3);
        check_output("mid_valid_pre", 64'(src_valid), 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_output("mid_valid_rst", 64'(src_valid), 64'd0);
        check_output("mid_count_rst", 64'(pkt_count), 64'd0);
        check_output("mid_ack_rst", 64'(ack), 64'd0);
        check_output("mid_grant_rst", 64'(grant_port), 64'd0);
        check_output("mid_addr_rst", 64'(src_addr), 64'd0);
        for (int p = 0; p < N; p++) begin
            remaining[p] = 1;
            expect_pkt(p, seq[p]);
        end
        apply_stimulus();
        step();
        check_output("mid_first_grant", 64'(grant_port), 64'd0);
        repeat (4) step();
        check_output("mid_sb_empty", 64'(sb_q.size()), 64'd0);
        check_output("mid_count_post", 64'(pkt_count), 64'd4);

        // Twenty single-port packets: counter saturation and ack spacing.
        $display("[TB] saturation and single-port spacing");
        do_reset(1);
        remaining[1] = 20;
        for (int s = 0; s < 20; s++) expect_pkt(1, s);
        track_spacing = 1;
        apply_stimulus();
        repeat (42) step();
        track_spacing = 0;
        check_output("sat_pkt_count", 64'(pkt_count), 64'd15);
        check_output("sat_sb_empty", 64'(sb_q.size()), 64'd0);
        check_output("sat_valid", 64'(src_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
